// File: rtl/press_pkg.sv
// Package press_pkg: types and helpers shared by the press classifier files.
//   press_state_e  - gesture FSM states
//   MS_DIV         - cycles-per-second to cycles-per-millisecond divisor
//   ms_to_cycles   - converts a millisecond duration into clock cycles
package press_pkg;

    localparam int MS_DIV = 1000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED   = 3'd1,
        LONG_HELD = 3'd2,
        WAIT_GAP  = 3'd3,
        SECOND    = 3'd4
    } press_state_e;

    // freq must be a multiple of MS_DIV so the division is exact.
    function automatic int ms_to_cycles(input int freq, input int ms);
        return (freq / MS_DIV) * ms;
    endfunction

endpackage

// File: rtl/press_classifier_ms_timer.sv
// Module ms_timer: up-counter with synchronous clear, count enable and a
// terminal-count flag against a run-time limit.
//   clk_i    in  clock
//   rst_i    in  asynchronous active-high reset (counter to 0)
//   clr_i    in  clear counter to 0 on the next edge (beats enable)
//   en_i     in  increment counter on the next edge
//   limit_i  in  W-bit terminal value
//   tc_o     out high while the counter equals limit_i
module ms_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/press_classifier.sv
// Module press_classifier: turns the debounced switch level and press tick
// into exactly one short-press, long-press or double-click pulse per gesture.
//   clk_i           in  system clock
//   rst_i           in  asynchronous active-high reset
//   db_level_i      in  debounced level, 1 = pressed
//   db_tick_i       in  one-cycle pulse on debounced 0->1 transition
//   short_press_o   out one-cycle pulse, single short press
//   long_press_o    out one-cycle pulse, press held past the long threshold
//   double_click_o  out one-cycle pulse, two short presses within the gap
//   busy_o          out high whenever a gesture is in progress
// Build option: define PRESS_CLASSIFIER_REPEAT_EN to make long_press_o repeat
// every RepeatMs while the button stays held after the first long pulse.
module press_classifier
    import press_pkg::*;
#(
    parameter int ClkFreq     = 100_000_000,
    parameter int LongPressMs = 1000,
    parameter int DoubleGapMs = 250,
    parameter int RepeatMs    = 200
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic db_level_i,
    input  logic db_tick_i,
    output logic short_press_o,
    output logic long_press_o,
    output logic double_click_o,
    output logic busy_o
);

    localparam int LongCycles = ms_to_cycles(ClkFreq, LongPressMs);
    localparam int GapCycles  = ms_to_cycles(ClkFreq, DoubleGapMs);
    localparam int RepCycles  = ms_to_cycles(ClkFreq, RepeatMs);
    localparam int MaxLg      = (LongCycles > GapCycles) ? LongCycles : GapCycles;
    localparam int MaxCycles  = (MaxLg > RepCycles) ? MaxLg : RepCycles;
    localparam int CntW       = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] LongLim = CntW'(LongCycles - 1);
    localparam logic [CntW-1:0] GapLim  = CntW'(GapCycles - 1);
    localparam logic [CntW-1:0] RepLim  = CntW'(RepCycles - 1);

    press_state_e    state_q, state_d;
    logic            short_q, short_d;
    logic            long_q, long_d;
    logic            double_q, double_d;
    logic            rep_restart;
    logic            timer_clr, timer_en, timer_tc;
    logic [CntW-1:0] timer_limit;

    ms_timer #(.W(CntW)) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (timer_clr),
        .en_i    (timer_en),
        .limit_i (timer_limit),
        .tc_o    (timer_tc)
    );

    // State register and registered event pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
        end
    end

    // Next-state logic. Release beats terminal count, and a second tick
    // beats the gap timeout, so each check order below matters.
    always_comb begin
        state_d     = state_q;
        short_d     = 1'b0;
        long_d      = 1'b0;
        double_d    = 1'b0;
        rep_restart = 1'b0;
        case (state_q)
            IDLE: begin
                if (db_tick_i) state_d = PRESSED;
            end
            PRESSED: begin
                if (!db_level_i) begin
                    state_d = WAIT_GAP;
                end else if (timer_tc) begin
                    long_d  = 1'b1;
                    state_d = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (!db_level_i) begin
                    state_d = IDLE;
                end
`ifdef PRESS_CLASSIFIER_REPEAT_EN
                else if (timer_tc) begin
                    long_d      = 1'b1;
                    rep_restart = 1'b1;
                end
`endif
            end
            WAIT_GAP: begin
                if (db_tick_i) begin
                    state_d = SECOND;
                end else if (timer_tc) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end
            end
            SECOND: begin
                if (!db_level_i) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                end else if (timer_tc) begin
                    long_d  = 1'b1;
                    state_d = LONG_HELD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Timer control and status outputs.
    always_comb begin
        timer_clr   = (state_d != state_q) || rep_restart;
        timer_en    = (state_q != IDLE);
        timer_limit = LongLim;
        case (state_q)
            WAIT_GAP:  timer_limit = GapLim;
            LONG_HELD: begin
                timer_limit = RepLim;
`ifndef PRESS_CLASSIFIER_REPEAT_EN
                timer_en    = 1'b0;
`endif
            end
            default:   timer_limit = LongLim;
        endcase
        busy_o = (state_q != IDLE);
    end

    assign short_press_o  = short_q;
    assign long_press_o   = long_q;
    assign double_click_o = double_q;

endmodule

// File: tb/tb_press_classifier.sv
module tb_press_classifier;

    localparam int L = 20;
    localparam int G = 5;
    localparam int R = 4;

    localparam logic [2:0] K_SHORT = 3'b001;
    localparam logic [2:0] K_LONG  = 3'b010;
    localparam logic [2:0] K_DBL   = 3'b100;

    logic clk = 1'b0;
    logic rst_i;
    logic db_level_i;
    logic db_tick_i;
    logic short_press_o, long_press_o, double_click_o, busy_o;

    press_classifier #(
        .ClkFreq     (1000),
        .LongPressMs (L),
        .DoubleGapMs (G),
        .RepeatMs    (R)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .db_level_i     (db_level_i),
        .db_tick_i      (db_tick_i),
        .short_press_o  (short_press_o),
        .long_press_o   (long_press_o),
        .double_click_o (double_click_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  errors   = 0;
    int  edge_cnt = 0;
    int  mon_cnt  = 0;

    // Inputs set here are sampled by the next rising edge; returns 1 time
    // unit after that edge, whose index is edge_cnt.
    task automatic step(input logic lvl, input logic tk);
        db_level_i = lvl;
        db_tick_i  = tk;
        @(posedge clk);
        edge_cnt++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // Held for edges 1..h-1 after the press, released at edge h.
    // Spurious ticks while held must be ignored by the DUT.
    task automatic hold(input int h);
        for (int i = 1; i < h; i++) step(1'b1, $urandom_range(0, 7) == 0);
        step(1'b0, 1'b0);
    endtask

    task automatic push(input int c, input logic [2:0] k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        exp_q.push_back(e);
    endtask

    // A press starting at edge 'start' and released at start+h: long at
    // start+L if still held, then optional repeats every R while held.
    task automatic push_hold(input int start, input int h);
        if (h > L) begin
            push(start + L, K_LONG);
`ifdef PRESS_CLASSIFIER_REPEAT_EN
            for (int k = 1; start + L + k * R < start + h; k++)
                push(start + L + k * R, K_LONG);
`endif
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at edge %0d", nm, act, req, edge_cnt);
        end
    endtask

    // g in 1..G means a second press g edges after the first release.
    task automatic gesture(input int h1, input int g, input int h2);
        int t, r, s;
        $display("gesture h1=%0d g=%0d h2=%0d from edge %0d", h1, g, h2, edge_cnt + 1);
        step(1'b1, 1'b1);
        t = edge_cnt;
        check_bit("busy_after_tick", busy_o, 1'b1);
        push_hold(t, h1);
        hold(h1);
        r = t + h1;
        if (h1 <= L) begin
            if (g >= 1 && g <= G) begin
                idle(g - 1);
                step(1'b1, 1'b1);
                s = edge_cnt;
                if (h2 <= L) push(s + h2, K_DBL);
                else         push_hold(s, h2);
                hold(h2);
            end else begin
                push(r + G, K_SHORT);
                idle(G);
            end
        end
        idle($urandom_range(1, 3));
        check_bit("busy_idle_after_gesture", busy_o, 1'b0);
    endtask

    // Monitor: compares every cycle where an event is due or any pulse is seen.
    initial begin
        logic [2:0] act;
        ev_t        e;
        forever begin
            @(posedge clk);
            mon_cnt++;
            #2;
            act = {double_click_o, long_press_o, short_press_o};
            while (exp_q.size() > 0 && exp_q[0].cyc < mon_cnt) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL stale_event cyc=%0d required kind=%b", e.cyc, e.kind);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == mon_cnt) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e.kind) begin
                    errors++;
                    $display("FAIL event cyc=%0d actual=%b required=%b", mon_cnt, act, e.kind);
                end else begin
                    $display("event cyc=%0d kind=%b ok", mon_cnt, act);
                end
            end else if (act !== 3'b000) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d actual=%b required=000", mon_cnt, act);
            end
        end
    end

    initial begin
        rst_i      = 1'b1;
        db_level_i = 1'b0;
        db_tick_i  = 1'b0;
        idle(3);
        check_bit("reset_busy", busy_o, 1'b0);
        check_bit("reset_short", short_press_o, 1'b0);
        check_bit("reset_long", long_press_o, 1'b0);
        check_bit("reset_double", double_click_o, 1'b0);
        rst_i = 1'b0;
        idle(2);

        // Directed boundary gestures.
        gesture(8, 0, 0);          // short
        gesture(30, 0, 0);         // long (plus repeats if enabled)
        gesture(4, 2, 3);          // double
        gesture(4, G, 3);          // second tick on the gap-timeout edge
        gesture(L, 0, 0);          // release on the long terminal edge
        gesture(L + 1, 0, 0);      // first edge that makes a long press
        gesture(3, 1, L);          // second press released on terminal edge
        gesture(3, 1, L + 1);      // second press turns into long
        gesture(4, G + 1, 3);      // gap too long: short only
        gesture(1, 1, 1);          // minimum durations

        // Reset in the middle of a press: nothing may come out of it.
        $display("reset mid-gesture from edge %0d", edge_cnt + 1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        rst_i = 1'b1;
        #1;
        check_bit("midreset_busy", busy_o, 1'b0);
        check_bit("midreset_long", long_press_o, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
        rst_i = 1'b0;
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
        idle(10);
        check_bit("after_midreset_busy", busy_o, 1'b0);

        // Random gestures.
        for (int n = 0; n < 40; n++)
            gesture($urandom_range(1, 30), $urandom_range(0, 7), $urandom_range(1, 26));

        idle(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
